// File: rtl/twp_master.sv
// Two-wire protocol host: serialises single-word register writes and read
// commands onto SDA (LSB first), then captures the slave's read response.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | bus released, ready=1, waiting for req
// START    | drive SDA=0 for one cycle
// CMD      | drive command bit (1=write, 0=read)
// ADDR     | drive addr[0]..addr[7]
// WDATA    | drive wdata[0]..wdata[15]
// TURN     | release SDA for one turnaround cycle
// WAIT_PRE | watch for slave preamble (1 then 0), bounded by TIMEOUT
// RDATA    | sample 16 response bits from SDA
// GAP      | bus released, SCL=1 for GAP_CYCLES before returning to IDLE
module twp_master #(
  parameter int TIMEOUT    = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        cmd,
  input  logic [7:0]  addr,
  input  logic [15:0] wdata,
  output logic        ready,
  output logic        done,
  output logic [15:0] rdata,
  output logic        err,
  output logic        SCL,
  inout  wire         SDA
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_START, ST_CMD, ST_ADDR, ST_WDATA,
    ST_TURN, ST_WAIT_PRE, ST_RDATA, ST_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    bit_q, bit_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          prev_one_q, prev_one_d;
  logic [15:0]   rx_q, rx_d;
  logic [15:0]   rdata_d;
  logic          cmd_q, cmd_d;
  logic [7:0]    addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          done_d, err_d, ready_d, scl_d;
  logic          sda_oe, sda_oe_d, sda_o, sda_o_d;
  logic          sda_bit;

  assign SDA = sda_oe ? sda_o : 1'bz;

  // Resolve the shared wire: anything other than a clean 0 reads as pulled-up 1
  always_comb begin
    case (SDA)
      1'b0:    sda_bit = 1'b0;
      default: sda_bit = 1'b1;
    endcase
  end

  // Next-state, counters, and registered-output next values
  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    tmr_d      = tmr_q;
    gap_d      = gap_q;
    prev_one_d = prev_one_q;
    rx_d       = rx_q;
    rdata_d    = rdata;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req && ready) begin
          cmd_d   = cmd;
          addr_d  = addr;
          wdata_d = wdata;
          state_d = ST_START;
        end
      end
      ST_START: state_d = ST_CMD;
      ST_CMD: begin
        bit_d   = 4'd0;
        state_d = ST_ADDR;
      end
      ST_ADDR: begin
        if (bit_q == 4'd7) begin
          bit_d   = 4'd0;
          state_d = cmd_q ? ST_WDATA : ST_TURN;
        end else begin
          bit_d = bit_q + 4'd1;
        end
      end
      ST_WDATA: begin
        if (bit_q == 4'd15) begin
          gap_d   = GW'(GAP_CYCLES);
          done_d  = 1'b1;
          state_d = ST_GAP;
        end else begin
          bit_d = bit_q + 4'd1;
        end
      end
      ST_TURN: begin
        tmr_d      = TW'(TIMEOUT);
        prev_one_d = 1'b0;
        state_d    = ST_WAIT_PRE;
      end
      ST_WAIT_PRE: begin
        prev_one_d = sda_bit;
        if (prev_one_q && !sda_bit) begin
          bit_d   = 4'd0;
          state_d = ST_RDATA;
        end else if (tmr_q <= TW'(1)) begin
          gap_d   = GW'(GAP_CYCLES);
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = ST_GAP;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      ST_RDATA: begin
        rx_d = {sda_bit, rx_q[15:1]};
        if (bit_q == 4'd15) begin
          rdata_d = {sda_bit, rx_q[15:1]};
          gap_d   = GW'(GAP_CYCLES);
          done_d  = 1'b1;
          state_d = ST_GAP;
        end else begin
          bit_d = bit_q + 4'd1;
        end
      end
      ST_GAP: begin
        if (gap_q <= GW'(1)) state_d = ST_IDLE;
        else                 gap_d   = gap_q - GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    // Bus drive is computed for the state being entered so SDA lines up with it
    sda_oe_d = 1'b0;
    sda_o_d  = 1'b1;
    case (state_d)
      ST_START: begin sda_oe_d = 1'b1; sda_o_d = 1'b0;                end
      ST_CMD:   begin sda_oe_d = 1'b1; sda_o_d = cmd_d;               end
      ST_ADDR:  begin sda_oe_d = 1'b1; sda_o_d = addr_d[bit_d[2:0]];  end
      ST_WDATA: begin sda_oe_d = 1'b1; sda_o_d = wdata_d[bit_d];      end
      default:  begin sda_oe_d = 1'b0; sda_o_d = 1'b1;                end
    endcase
    scl_d   = (state_d == ST_IDLE) || (state_d == ST_GAP);
    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers; reset aborts any frame without a done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bit_q      <= 4'd0;
      tmr_q      <= '0;
      gap_q      <= '0;
      prev_one_q <= 1'b0;
      rx_q       <= 16'd0;
      rdata      <= 16'd0;
      cmd_q      <= 1'b0;
      addr_q     <= 8'd0;
      wdata_q    <= 16'd0;
      done       <= 1'b0;
      err        <= 1'b0;
      ready      <= 1'b0;
      SCL        <= 1'b1;
      sda_oe     <= 1'b0;
      sda_o      <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      tmr_q      <= tmr_d;
      gap_q      <= gap_d;
      prev_one_q <= prev_one_d;
      rx_q       <= rx_d;
      rdata      <= rdata_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      done       <= done_d;
      err        <= err_d;
      ready      <= ready_d;
      SCL        <= scl_d;
      sda_oe     <= sda_oe_d;
      sda_o      <= sda_o_d;
    end
  end

endmodule

// File: tb/tb_twp_master.sv
// Directed bench for twp_master: frame serialisation, read response capture,
// preamble timeout, back-to-back requests, mid-frame reset and boundary values.
module tb_twp_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        cmd;
  logic [7:0]  addr;
  logic [15:0] wdata;
  wire         ready, done, err, SCL;
  wire  [15:0] rdata;
  wire         SDA;

  logic        tb_oe = 1'b0;
  logic        tb_o  = 1'b1;
  logic [15:0] mem [0:255];

  int checks   = 0;
  int failures = 0;

  assign SDA = tb_oe ? tb_o : 1'bz;
  pullup (SDA);

  // Free-running clock
  always #5 clk = ~clk;

  twp_master #(.TIMEOUT(8), .GAP_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .req(req), .cmd(cmd), .addr(addr),
    .wdata(wdata), .ready(ready), .done(done), .rdata(rdata),
    .err(err), .SCL(SCL), .SDA(SDA)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout observed=%0b expected=1", ready);
    end
  endtask

  task automatic issue(input logic c, input logic [7:0] a, input logic [15:0] d, input bit hold);
    wait_ready();
    req = 1'b1; cmd = c; addr = a; wdata = d;
    @(negedge clk);
    if (!hold) req = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [15:0] d, input bit hold);
    logic [25:0] exp_bits;
    logic [25:0] obs;
    bit scl_bad = 0;
    bit done_early = 0;
    exp_bits = {d, a, 1'b1, 1'b0};
    issue(1'b1, a, d, hold);
    for (int i = 0; i < 26; i++) begin
      obs[i] = SDA;
      if (SCL !== 1'b0) scl_bad = 1;
      if (done !== 1'b0) done_early = 1;
      @(negedge clk);
    end
    chk("wr_frame_bits", 32'(obs), 32'(exp_bits));
    chk("wr_scl_low_in_frame", 32'(scl_bad), 0);
    chk("wr_no_early_done", 32'(done_early), 0);
    chk("wr_done_pulse", 32'(done), 1);
    chk("wr_err_clear", 32'(err), 0);
    chk("wr_sda_released", 32'(SDA), 1);
    mem[obs[9:2]] = obs[25:10];
    @(negedge clk);
    chk("wr_done_one_cycle", 32'(done), 0);
  endtask

  task automatic do_read(input logic [7:0] a, input bit respond, input logic [15:0] exp_rdata, input bit hold);
    logic [9:0]  obs;
    logic [15:0] resp;
    int n;
    issue(1'b0, a, 16'h0000, hold);
    for (int i = 0; i < 10; i++) begin
      obs[i] = SDA;
      @(negedge clk);
    end
    chk("rd_frame_bits", 32'(obs), 32'({a, 1'b0, 1'b0}));
    chk("rd_turn_released", 32'(SDA), 1);
    chk("rd_turn_scl_low", 32'(SCL), 0);
    @(negedge clk);
    if (respond) begin
      resp  = mem[a];
      tb_oe = 1'b1; tb_o = 1'b1;
      @(negedge clk);
      tb_o = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
        tb_o = resp[i];
        @(negedge clk);
      end
      tb_oe = 1'b0; tb_o = 1'b1;
      chk("rd_done", 32'(done), 1);
      chk("rd_err", 32'(err), 0);
      chk("rd_rdata", 32'(rdata), 32'(exp_rdata));
    end else begin
      n = 12;
      while (done !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("rd_timeout_latency", n, 20);
      chk("rd_timeout_err", 32'(err), 1);
      chk("rd_timeout_rdata_kept", 32'(rdata), 32'(exp_rdata));
    end
    @(negedge clk);
    chk("rd_done_one_cycle", 32'(done), 0);
  endtask

  // Directed sequence
  initial begin
    bit saw_done;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    reset = 1'b1; req = 1'b0; cmd = 1'b0; addr = 8'h00; wdata = 16'h0000;

    @(negedge clk);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_scl", 32'(SCL), 1);
    chk("rst_sda", 32'(SDA), 1);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(ready), 1);

    // Write then read back, then a read nobody answers
    do_write(8'h3C, 16'hA5F0, 0);
    chk("mem_3c", 32'(mem[8'h3C]), 32'h0000A5F0);
    do_read(8'h3C, 1, 16'hA5F0, 0);
    do_read(8'h77, 0, 16'hA5F0, 0);
    wait_ready();
    chk("ready_after_timeout", 32'(ready), 1);

    // req held high across alternating write/read/write
    do_write(8'h55, 16'h1234, 1);
    chk("b2b_gap1_scl", 32'(SCL), 1);
    chk("b2b_gap1_sda", 32'(SDA), 1);
    chk("b2b_gap1_ready", 32'(ready), 0);
    @(negedge clk);
    chk("b2b_idle_scl", 32'(SCL), 1);
    chk("b2b_idle_sda", 32'(SDA), 1);
    chk("b2b_idle_ready", 32'(ready), 1);
    do_read(8'h55, 1, 16'h1234, 1);
    chk("b2b_rd_gap_ready", 32'(ready), 0);
    do_write(8'h56, 16'h8001, 1);
    req = 1'b0;

    // Reset during ADDR bit 4 aborts the frame silently
    issue(1'b1, 8'hAA, 16'h5555, 0);
    for (int i = 0; i < 6; i++) @(negedge clk);
    chk("abort_addr_bit4", 32'(SDA), 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_sda", 32'(SDA), 1);
    chk("abort_scl", 32'(SCL), 1);
    chk("abort_ready", 32'(ready), 0);
    saw_done = 0;
    for (int i = 0; i < 3; i++) begin
      if (done !== 1'b0) saw_done = 1;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(saw_done), 0);
    chk("abort_ready_back", 32'(ready), 1);
    do_write(8'h01, 16'hBEEF, 0);
    do_read(8'h01, 1, 16'hBEEF, 0);

    // Boundary values
    do_write(8'hFF, 16'hFFFF, 0);
    do_write(8'h00, 16'h0000, 0);
    do_read(8'hFF, 1, 16'hFFFF, 0);
    do_read(8'h00, 1, 16'h0000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
